// File: rtl/if_stage.sv
// Instruction-fetch stage: credit-limited imem requests, in-order response FIFO,
// and the registered inst/pc pair handed to decode.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        br_i,
    input  logic [31:0] br_addr_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_valid_o
);

    localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CW1 = CW + 1;
    localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    fetch_entry_t  mem_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [31:0]   pc_q, pc_d, rsp_pc_q, rsp_pc_d;
    logic [31:0]   inst_q, inst_d, pc_out_q, pc_out_d;
    logic          valid_q, valid_d;
    logic          redirect_c, fire_c, rsp_c, push_c, pop_c;
    logic [CW1-1:0] inflight_c;
    logic [31:0]   br_target_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A stalled decode has not resolved its operands, so its branch is not trusted yet.
    assign redirect_c  = br_i & ~stall_i;
    assign br_target_c = br_addr_i & 32'hFFFF_FFFC;
    assign inflight_c  = CW1'(outst_q) + CW1'(count_q);

    assign imem_req_o   = rst & ~redirect_c & (inflight_c < CW1'(FIFO_DEPTH));
    assign imem_addr_o  = pc_q;
    assign inst_o       = inst_q;
    assign pc_o         = pc_out_q;
    assign inst_valid_o = valid_q;

    // Next-state logic for request counter, response FIFO and output register.
    always_comb begin
        pc_d      = pc_q;
        rsp_pc_d  = rsp_pc_q;
        outst_d   = outst_q;
        discard_d = discard_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        inst_d    = inst_q;
        pc_out_d  = pc_out_q;
        valid_d   = valid_q;
        push_c    = 1'b0;
        pop_c     = 1'b0;
        fire_c    = imem_req_o & imem_gnt_i;
        rsp_c     = imem_rvalid_i & (outst_q != '0);

        if (fire_c) begin
            pc_d = pc_q + 32'd4;
        end
        outst_d = outst_q + CW'(fire_c) - CW'(rsp_c);

        if (redirect_c) begin
            pc_d      = br_target_c;
            rsp_pc_d  = br_target_c;
            count_d   = '0;
            rd_ptr_d  = '0;
            wr_ptr_d  = '0;
            discard_d = outst_q - CW'(rsp_c);
            inst_d    = NOP_INST;
            valid_d   = 1'b0;
        end else begin
            if (rsp_c) begin
                if (discard_q != '0) begin
                    discard_d = discard_q - CW'(1);
                end else begin
                    push_c   = 1'b1;
                    rsp_pc_d = rsp_pc_q + 32'd4;
                    wr_ptr_d = ptr_inc(wr_ptr_q);
                end
            end
            if (!stall_i) begin
                if (count_q != '0) begin
                    pop_c    = 1'b1;
                    inst_d   = mem_q[rd_ptr_q].inst;
                    pc_out_d = mem_q[rd_ptr_q].pc;
                    valid_d  = 1'b1;
                    rd_ptr_d = ptr_inc(rd_ptr_q);
                end else begin
                    inst_d  = NOP_INST;
                    valid_d = 1'b0;
                end
            end
            count_d = count_q + CW'(push_c) - CW'(pop_c);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q      <= RESET_PC;
            rsp_pc_q  <= RESET_PC;
            outst_q   <= '0;
            discard_q <= '0;
            count_q   <= '0;
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            inst_q    <= NOP_INST;
            pc_out_q  <= '0;
            valid_q   <= 1'b0;
        end else begin
            pc_q      <= pc_d;
            rsp_pc_q  <= rsp_pc_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            inst_q    <= inst_d;
            pc_out_q  <= pc_out_d;
            valid_q   <= valid_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= '{pc: rsp_pc_q, inst: imem_rdata_i};
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: transaction-level scoreboard of the fetched PC stream
// against a latency-randomised instruction memory.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam int          DEPTH    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        br_i = 1'b0;
    logic [31:0] br_addr_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i = 1'b0;
    logic        imem_rvalid_i = 1'b0;
    logic [31:0] imem_rdata_i = '0;
    logic [31:0] inst_o;
    logic [31:0] pc_o;
    logic        inst_valid_o;

    if_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .br_i(br_i), .br_addr_i(br_addr_i),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
        .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .inst_o(inst_o), .pc_o(pc_o), .inst_valid_o(inst_valid_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Instruction memory: contents are a pure function of the address.
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    // Memory responder: in-order responses, per-request latency, optional random grant.
    logic [31:0] q_addr[$];
    int          q_due[$];
    int          cyc = 0;
    int          lat_min = 1, lat_max = 1, gnt_pct = 100;
    bit          gnt_en = 1'b1;

    always @(negedge clk) begin
        imem_gnt_i <= gnt_en && ($urandom_range(99) < gnt_pct);
        if (q_addr.size() != 0 && q_due[0] <= cyc) begin
            imem_rvalid_i <= 1'b1;
            imem_rdata_i  <= memf(q_addr[0]);
        end else begin
            imem_rvalid_i <= 1'b0;
            imem_rdata_i  <= $urandom();
        end
    end

    always @(posedge clk) begin
        if (imem_rvalid_i && q_addr.size() != 0) begin
            void'(q_addr.pop_front());
            void'(q_due.pop_front());
        end
        if (imem_req_o && imem_gnt_i) begin
            q_addr.push_back(imem_addr_o);
            q_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
        end
        cyc <= cyc + 1;
    end

    // Reference state: next PC decode should see, next PC to be fetched,
    // and what the output register should currently hold.
    logic [31:0] exp_pc    = RESET_PC;
    logic [31:0] exp_fetch = RESET_PC;
    logic [31:0] m_pc      = 32'h0;
    logic [31:0] m_inst    = NOP_INST;
    logic        m_valid   = 1'b0;
    int          edge_n = 0, first_gnt = -1, first_valid = -1, delivered = 0;
    bit          deliv_now, last_req;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag);
        chk({tag, "_inst"}, inst_o, m_inst);
        chk({tag, "_pc"}, pc_o, m_pc);
        chk({tag, "_valid"}, 32'(inst_valid_o), 32'(m_valid));
    endtask

    // One clock: sample request side before the edge, score outputs after it.
    task automatic tick();
        logic req_s, gnt_s, redir;
        logic [31:0] addr_s;
        @(negedge clk); #1;
        req_s  = imem_req_o;
        gnt_s  = imem_gnt_i;
        addr_s = imem_addr_o;
        last_req = req_s;
        redir  = rst && br_i && !stall_i;
        if (!rst) chk("req_in_reset", 32'(req_s), 32'd0);
        if (redir) chk("req_on_redirect", 32'(req_s), 32'd0);
        if (rst && req_s && gnt_s) begin
            chk("fetch_addr", addr_s, exp_fetch);
            exp_fetch = exp_fetch + 32'd4;
            if (first_gnt < 0) first_gnt = edge_n + 1;
        end
        @(posedge clk); #1;
        edge_n++;
        deliv_now = 1'b0;
        if (!rst) begin
            exp_pc = RESET_PC; exp_fetch = RESET_PC;
            m_pc = 32'h0; m_inst = NOP_INST; m_valid = 1'b0;
            chk_out("reset");
        end else if (redir) begin
            exp_pc = br_addr_i & 32'hFFFF_FFFC;
            exp_fetch = exp_pc;
            m_inst = NOP_INST; m_valid = 1'b0;
            chk_out("redirect_bubble");
        end else if (stall_i) begin
            chk_out("stall_hold");
        end else if (inst_valid_o === 1'b1) begin
            chk("deliver_pc", pc_o, exp_pc);
            chk("deliver_inst", inst_o, memf(exp_pc));
            m_pc = exp_pc; m_inst = memf(exp_pc); m_valid = 1'b1;
            exp_pc = exp_pc + 32'd4;
            delivered++;
            deliv_now = 1'b1;
            if (first_valid < 0) first_valid = edge_n;
        end else begin
            m_inst = NOP_INST; m_valid = 1'b0;
            chk_out("bubble");
        end
    endtask

    task automatic wait_pc(input string tag, input logic [31:0] target, input int budget);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            tick();
            if (deliv_now && m_pc == target) hit = 1'b1;
        end
        chk(tag, 32'(hit), 32'd1);
    endtask

    initial begin
        // Reset held, then released with gnt=1 and 1-cycle latency
        tick(); tick();
        rst = 1'b1;
        wait_pc("t1_reach_8", 32'h8, 20);
        chk("t1_latency", 32'(first_valid - first_gnt), 32'd2);

        // Stall 3 cycles holding pc 0x8; credit must throttle requests
        stall_i = 1'b1;
        tick(); tick(); tick();
        chk("t2_req_drop", 32'(last_req), 32'd0);
        stall_i = 1'b0;
        wait_pc("t2_reach_10", 32'h10, 20);

        // Two requests in flight at 3-cycle latency, then redirect to 0x100
        lat_min = 3; lat_max = 3;
        begin
            bit two = 1'b0;
            for (int i = 0; i < 20 && !two; i++) begin
                tick();
                if (q_addr.size() == 2) two = 1'b1;
            end
            chk("t3_two_inflight", 32'(two), 32'd1);
        end
        br_i = 1'b1; br_addr_i = 32'h0000_0100;
        tick();
        br_i = 1'b0;
        wait_pc("t3_reach_100", 32'h100, 30);

        // Branch during stall is ignored, taken the following cycle (misaligned target)
        lat_min = 1; lat_max = 1;
        stall_i = 1'b1; br_i = 1'b1; br_addr_i = 32'h0000_0206;
        tick();
        stall_i = 1'b0;
        tick();
        br_i = 1'b0;
        wait_pc("t4_reach_204", 32'h204, 30);

        // Address wrap at the top of the 32-bit space
        br_i = 1'b1; br_addr_i = 32'hFFFF_FFF8;
        tick();
        br_i = 1'b0;
        wait_pc("t5_reach_0", 32'h0, 30);

        // Reset with one request outstanding; its late response must be ignored
        lat_min = 5; lat_max = 5; gnt_en = 1'b0;
        br_i = 1'b1; br_addr_i = 32'h0000_0300;
        tick();
        br_i = 1'b0;
        tick(); tick(); tick(); tick(); tick(); tick();
        gnt_en = 1'b1;
        tick();
        gnt_en = 1'b0;
        tick();
        chk("t6_one_inflight", 32'(q_addr.size()), 32'd1);
        rst = 1'b0;
        #1;
        chk("t6_async_inst", inst_o, NOP_INST);
        chk("t6_async_pc", pc_o, 32'h0);
        chk("t6_async_valid", 32'(inst_valid_o), 32'd0);
        chk("t6_async_req", 32'(imem_req_o), 32'd0);
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("t6_stale_drained", 32'(q_addr.size()), 32'd0);
        lat_min = 1; lat_max = 1; gnt_en = 1'b1;
        wait_pc("t6_reach_0", RESET_PC, 20);

        // Random traffic: grant gaps, variable latency, stalls and redirects
        lat_min = 1; lat_max = 3; gnt_pct = 70;
        begin
            int d0 = delivered;
            for (int i = 0; i < 400; i++) begin
                stall_i   = ($urandom_range(99) < 25);
                br_i      = ($urandom_range(99) < 8);
                br_addr_i = $urandom();
                tick();
            end
            stall_i = 1'b0; br_i = 1'b0;
            chk("rand_progress", 32'(delivered - d0 > 20), 32'd1);
        end
        gnt_pct = 100;
        wait_pc("rand_tail", exp_pc, 30);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage. It generates the fetch PC, issues requests to instruction memory over a req/gnt/rvalid handshake that tolerates variable latency, and buffers responses in a small FIFO.
- It drives the registered inst_o/pc_o pair that decode consumes.
- It honours the decode stall request and redirects on every br/br_addr from decode. Responses to requests already in flight at a redirect are discarded.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) presented when no valid instruction is available.
- FIFO_DEPTH, 2, response buffer entries; also the cap on outstanding requests plus buffered entries. Legal range 2..8.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- stall_i  in  1  decode stall request; holds the output register.
- br_i  in  1  redirect from decode, asserted for every control-transfer instruction.
- br_addr_i  in  32  next PC after the redirect.
- imem_req_o  out  1  fetch request valid.
- imem_addr_o  out  32  fetch address (word aligned).
- imem_gnt_i  in  1  request accepted this cycle.
- imem_rvalid_i  in  1  response data valid.
- imem_rdata_i  in  32  response instruction.
- inst_o  out  32  instruction to decode.
- pc_o  out  32  PC of inst_o.
- inst_valid_o  out  1  inst_o is a real fetched instruction; 0 means a bubble.

Behaviour:
- Reset (rst=0, asynchronous):
  - pc_q = rsp_pc_q = RESET_PC.
  - outstanding = 0, discard = 0, FIFO empty.
  - inst_o = NOP_INST, pc_o = 0, inst_valid_o = 0, imem_req_o = 0.
  - Reset mid-transaction drops all state. Responses arriving after reset release are ignored while outstanding = 0.
- redirect = br_i & ~stall_i. br_i is ignored while stall_i = 1, because decode operands are not yet valid in that cycle.
- Request side:
  - imem_req_o = rst & ~redirect & (outstanding + fifo_count < FIFO_DEPTH), using registered counts only.
  - imem_addr_o = pc_q.
  - req & gnt: pc_q <= pc_q + 4 (32-bit wrap, 32'hFFFF_FFFC -> 0), outstanding++.
  - imem_addr_o must stay stable while req=1 and gnt=0.
- Response side:
  - Every rvalid does outstanding--.
  - If discard > 0: discard--, data dropped.
  - Otherwise push {rsp_pc_q, imem_rdata_i} into the FIFO and do rsp_pc_q += 4.
  - The credit rule guarantees the FIFO never overflows.
  - rvalid with outstanding = 0 is a protocol violation and is ignored.
- Output register (updates only when stall_i = 0):
  - FIFO non-empty: pop, inst_o/pc_o <= head, inst_valid_o <= 1.
  - FIFO empty: inst_o <= NOP_INST, inst_valid_o <= 0, pc_o holds.
  - stall_i = 1: inst_o, pc_o, inst_valid_o hold; FIFO does not pop; requests and responses continue.
- Redirect cycle:
  - pc_q <= br_addr_i and rsp_pc_q <= br_addr_i, with br_addr_i[1:0] forced to 0.
  - FIFO cleared; no pop that cycle.
  - inst_o <= NOP_INST, inst_valid_o <= 0.
  - discard <= outstanding - (imem_rvalid_i ? 1 : 0), i.e. every in-flight response is stale.
  - Any push that would happen this cycle is dropped.
- Simultaneous push and pop on a non-empty FIFO is allowed; fifo_count is unchanged.
- Latency: from req & gnt with 1-cycle rvalid, the instruction appears on inst_o at the earliest 2 cycles after gnt.
- Counter widths are $clog2(FIFO_DEPTH+1); discard never exceeds FIFO_DEPTH.

Test Plan:
1. Reset release, memory returns rvalid the cycle after each gnt, gnt always 1 → addresses 0x0, 0x4, 0x8…; inst_o sequence matches memory with pc_o 0x0, 0x4…; inst_valid_o rises 2 cycles after the first gnt.
2. Hold stall_i = 1 for 3 cycles with inst_o = mem[0x8] → inst_o/pc_o held at 0x8; imem_req_o drops once outstanding + fifo_count = 2; after release, 0xC and 0x10 delivered with no loss or duplication.
3. Memory latency 3 cycles, 2 requests outstanding, then br_i = 1, br_addr_i = 0x100 → both late responses discarded; next valid inst_o has pc_o = 0x100 and the 0x100 instruction; one bubble (NOP, valid 0) on the redirect edge.
4. br_i = 1 together with stall_i = 1 → no redirect, outputs held; br_i = 1 with stall_i = 0 on the next cycle → redirect taken.
5. pc_q = 0xFFFF_FFF8, no redirects → fetch addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0.
6. Assert rst low while 1 request is outstanding → outputs at reset values immediately; after release, the first fetch is at RESET_PC and the stale rvalid is ignored.
